mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand or dividend.
REQ-007 SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-008 SHALL have port flush, input, 1 bit: abort the operation in flight.
REQ-009 SHALL have ports hi_we and lo_we, inputs, 1 bit each: MTHI and MTLO write enables.
REQ-010 SHALL have port wdata, input, WIDTH bits: MTHI/MTLO write data.
REQ-011 SHALL have port busy, output, 1 bit: operation in progress; pipeline stall request.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-013 SHALL have ports hi and lo, outputs, WIDTH bits each: registered HI/LO, consumed by the write-back select mux.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-015 Transitions SHALL be:
  - IDLE -> CALC when start=1.
  - CALC -> FIX after exactly WIDTH iterations, tracked by an iteration counter.
  - FIX -> DONE.
  - DONE -> IDLE.
REQ-016 start SHALL be accepted only in IDLE; start in CALC, FIX or DONE SHALL be ignored.
REQ-017 Latency SHALL be fixed: start accepted at cycle T gives done=1 and new hi/lo visible at cycle T+WIDTH+2, independent of operand values.
REQ-018 Outputs SHALL be: busy=1 in CALC and FIX; done=1 only in DONE; both 0 otherwise.
REQ-019 Operands a, b and op SHALL be latched at acceptance; later input changes SHALL have no effect.
REQ-020 Multiply SHALL be radix-2 shift-add producing a 2*WIDTH product: hi = upper half, lo = lower half.
REQ-021 Divide SHALL be restoring, one quotient bit per CALC cycle: lo = quotient, hi = remainder.
REQ-022 Signed ops SHALL iterate on magnitudes and apply the sign correction in FIX:
  - product sign = sign(a) XOR sign(b).
  - quotient truncates toward zero.
  - remainder takes the sign of the dividend.
REQ-023 Division by zero SHALL keep the same latency and produce lo = all ones, hi = a as latched.
REQ-024 Signed overflow case (most-negative / -1) SHALL produce lo = most-negative value, hi = 0.
REQ-025 hi and lo SHALL be updated only in the cycle entering DONE, or by hi_we/lo_we.
REQ-026 hi_we/lo_we SHALL write wdata to hi/lo only in IDLE and SHALL be ignored in any other state.
REQ-027 If start and hi_we/lo_we are asserted together in IDLE, start SHALL be accepted and the write SHALL be ignored.
REQ-028 flush=1 in CALC or FIX SHALL return the FSM to IDLE on the next edge with hi/lo unchanged and no done pulse.
REQ-029 flush=1 in IDLE or DONE SHALL have no effect.

Reset
REQ-030 reset_n=0 SHALL asynchronously force all of the following, including mid-operation:
  - state = IDLE, counter = 0.
  - hi = 0, lo = 0.
  - busy = 0, done = 0.
  - internal operand and accumulator registers = 0.
REQ-031 An operation interrupted by reset SHALL leave no trace; no done pulse SHALL follow reset release.

Configuration
REQ-032 Macro MDU_SIGNED_EN defined: MULT and DIV SHALL use the signed handling of REQ-022 and REQ-024.
REQ-033 Macro MDU_SIGNED_EN undefined: op[0] SHALL be ignored and all operations SHALL be unsigned.
REQ-034 With MDU_SIGNED_EN undefined, the FIX state SHALL remain as a pass-through so latency is unchanged.

Structure
REQ-035 A shared package SHALL hold the op encodings (MDU_OP_MULTU/MULT/DIVU/DIV), the FSM state encodings and the default WIDTH.
REQ-036 The iterative datapath MAY be a sub-module mdu_datapath; the FSM, counter, flush handling and HI/LO registers SHALL stay in mult_div_unit.

Verification
REQ-037 MULTU a=7, b=6: done at T+34, hi=0x00000000, lo=0x0000002A; busy high T+1..T+33.
REQ-038 MULT a=-3, b=5 (MDU_SIGNED_EN): hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-039 DIVU a=100, b=7: lo=14, hi=2. DIV a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 DIVU a=0x1234, b=0: done at T+34, lo=0xFFFFFFFF, hi=0x00001234.
REQ-041 hi_we with wdata=0xAAAA5555 in IDLE: hi updated next cycle; hi_we during CALC: ignored; start in DONE: ignored.
REQ-042 Abort cases:
  - flush at T+10: IDLE at T+11, hi/lo keep their prior values, no done pulse.
  - reset_n low at T+5: all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared op encodings, FSM states and default width for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int MDU_WIDTH_DEFAULT = 32;

    localparam logic [1:0] MDU_OP_MULTU = 2'b00;
    localparam logic [1:0] MDU_OP_MULT  = 2'b01;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b10;
    localparam logic [1:0] MDU_OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_FIX  = 2'd2,
        MDU_ST_DONE = 2'd3
    } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_datapath.sv
// ============================================================================
// Module   : mdu_datapath
// Brief    : Iterative shift-add multiply / restoring divide on magnitudes,
//            with sign correction presented combinationally on o_hi/o_lo.
//            Signed handling is compiled in only when MDU_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

`ifdef MDU_SIGNED_EN
    localparam logic c_SIGNED_EN = 1'b1;
`else
    localparam logic c_SIGNED_EN = 1'b0;
`endif

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_b_zero;

    logic               w_is_div;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_is_div = (i_op == MDU_OP_DIVU) || (i_op == MDU_OP_DIV);
    assign w_signed = c_SIGNED_EN & ((i_op == MDU_OP_MULT) || (i_op == MDU_OP_DIV));
    assign w_sa     = w_signed & i_a[WIDTH-1];
    assign w_sb     = w_signed & i_b[WIDTH-1];
    assign w_mag_a  = w_sa ? -i_a : i_a;
    assign w_mag_b  = w_sb ? -i_b : i_b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_opnd};
    assign w_ge       = (w_shift >= {1'b0, r_opnd});
    assign w_div_next = w_ge ? {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1}
                             : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
            r_a_raw  <= i_a;
            r_is_div <= w_is_div;
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa;
            r_b_zero <= (i_b == '0);
        end else if (i_step) begin
            r_acc    <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    always_comb begin
        o_hi = r_acc[2*WIDTH-1:WIDTH];
        o_lo = r_acc[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                o_hi = r_a_raw;
                o_lo = '1;
            end else begin
                if (r_neg_lo) o_lo = -r_acc[WIDTH-1:0];
                if (r_neg_hi) o_hi = -r_acc[2*WIDTH-1:WIDTH];
            end
        end else if (r_neg_lo) begin
            {o_hi, o_lo} = -r_acc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Brief    : Fixed-latency multiply/divide unit with HI/LO registers, flush
//            and MTHI/MTLO writes. Signed ops enabled by MDU_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    mdu_state_t         r_state;
    mdu_state_t         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_load;
    logic               w_step;
    logic               w_commit;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= MDU_ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            MDU_ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = MDU_ST_CALC;
                end
            end
            MDU_ST_CALC: begin
                busy = 1'b1;
                if (flush) begin
                    w_next = MDU_ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == c_CNT_LAST) w_next = MDU_ST_FIX;
                end
            end
            MDU_ST_FIX: begin
                busy = 1'b1;
                if (flush) begin
                    w_next = MDU_ST_IDLE;
                end else begin
                    w_commit = 1'b1;
                    w_next   = MDU_ST_DONE;
                end
            end
            MDU_ST_DONE: begin
                done   = 1'b1;
                w_next = MDU_ST_IDLE;
            end
            default: w_next = MDU_ST_IDLE;
        endcase
    end

    // Counter runs only while iterating; any other cycle returns it to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_cnt <= '0;
        else if (w_step) r_cnt <= r_cnt + 1'b1;
        else             r_cnt <= '0;
    end

    // A start in IDLE takes priority over a simultaneous MTHI/MTLO write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (w_commit) begin
            hi <= w_res_hi;
            lo <= w_res_lo;
        end else if ((r_state == MDU_ST_IDLE) && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

    mdu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_hi    (w_res_hi),
        .o_lo    (w_res_lo)
    );

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit (WIDTH=32);
//            signed expectations follow MDU_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int nb;
    int ndone;

`ifdef MDU_SIGNED_EN
    localparam logic [31:0] c_MULT_HI = 32'hFFFF_FFFF, c_MULT_LO = 32'hFFFF_FFF1;
    localparam logic [31:0] c_DIV_HI  = 32'hFFFF_FFFF, c_DIV_LO  = 32'hFFFF_FFFD;
    localparam logic [31:0] c_OVF_HI  = 32'h0000_0000, c_OVF_LO  = 32'h8000_0000;
`else
    localparam logic [31:0] c_MULT_HI = 32'h0000_0004, c_MULT_LO = 32'hFFFF_FFF1;
    localparam logic [31:0] c_DIV_HI  = 32'h0000_0001, c_DIV_LO  = 32'h7FFF_FFFC;
    localparam logic [31:0] c_OVF_HI  = 32'h8000_0000, c_OVF_LO  = 32'h0000_0000;
`endif

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge while IDLE (cycle T); returns in cycle T+1.
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        op    = ~o;
        a     = ~av;
        b     = 32'h5A5A_0F0F;
    endtask

    // Advances until done, returning the cycle index relative to acceptance.
    task automatic wait_done(input int c0, output int c, output int nbusy);
        c     = c0;
        nbusy = 0;
        while (done !== 1'b1 && c < c0 + 100) begin
            if (busy === 1'b1) nbusy++;
            tick();
            c++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] o,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] eh, input logic [31:0] el);
        int c;
        int n;
        issue(o, av, bv);
        wait_done(1, c, n);
        chk({tag, "_lat"}, 64'(c), 64'd34);
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        flush   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        run_and_check("multu_7x6",   2'b00, 32'd7,          32'd6,          32'h0,       32'h2A);
        run_and_check("mult_m3x5",   2'b01, 32'hFFFF_FFFD,  32'd5,          c_MULT_HI,   c_MULT_LO);
        run_and_check("divu_100_7",  2'b10, 32'd100,        32'd7,          32'd2,       32'd14);
        run_and_check("div_m7_2",    2'b11, 32'hFFFF_FFF9,  32'd2,          c_DIV_HI,    c_DIV_LO);
        run_and_check("div_ovf",     2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  c_OVF_HI,    c_OVF_LO);
        run_and_check("divu_by0",    2'b10, 32'h0000_1234,  32'd0,          32'h1234,    32'hFFFF_FFFF);
        run_and_check("div_by0",     2'b11, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1;
        wdata = 32'hAAAA_5555;
        tick();
        hi_we = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hAAAA_5555);
        chk("mthi_lo", 64'(lo), 64'hFFFF_FFFF);
        lo_we = 1'b1;
        wdata = 32'h5555_AAAA;
        tick();
        lo_we = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h5555_AAAA);

        // start together with hi_we: start wins, write dropped
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd1;
        b     = 32'd1;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        chk("startwe_busy", 64'(busy), 64'd1);
        chk("startwe_hi",   64'(hi),   64'hAAAA_5555);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("calc_we_hi", 64'(hi), 64'hAAAA_5555);
        chk("calc_we_lo", 64'(lo), 64'h5555_AAAA);
        wait_done(2, cyc, nb);
        chk("one_lat", 64'(cyc), 64'd34);
        chk("one_hi",  64'(hi),  64'd0);
        chk("one_lo",  64'(lo),  64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_busy", 64'(busy), 64'd0);
        chk("done_start_done", 64'(done), 64'd0);
        tick();
        chk("done_start_idle", 64'(busy), 64'd0);

        // flush during CALC at T+10
        issue(2'b10, 32'd100, 32'd7);
        repeat (9) tick();
        chk("flush_calc_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_calc_busy", 64'(busy), 64'd0);
        chk("flush_calc_hi",   64'(hi),   64'd0);
        chk("flush_calc_lo",   64'(lo),   64'd1);
        ndone = 0;
        repeat (40) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("flush_calc_nodone", 64'(ndone), 64'd0);
        chk("flush_calc_lo2",    64'(lo),    64'd1);

        // flush during FIX at T+33
        issue(2'b00, 32'd7, 32'd6);
        repeat (32) tick();
        chk("flush_fix_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_fix_busy", 64'(busy), 64'd0);
        ndone = 0;
        repeat (5) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("flush_fix_nodone", 64'(ndone), 64'd0);
        chk("flush_fix_lo",     64'(lo),    64'd1);

        // asynchronous reset at T+5
        issue(2'b00, 32'd7, 32'd6);
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi",   64'(hi),   64'd0);
        chk("arst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("arst_quiet", 64'(ndone), 64'd0);

        run_and_check("post_rst_divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
